// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Holds the pipeline via stall_divE and returns {HI=rem, LO=quo} with a one-cycle ready pulse.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cancel,
  output logic               stall_divE,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     shift;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;
  logic [2*WIDTH-1:0] fin;
  logic               last_it;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_abs = a_neg ? ('0 - a) : a;
  assign b_abs = b_neg ? ('0 - b) : b;

  // Partial remainder stays below the divisor, so W+1 bits hold the shift.
  assign shift = {rem_q, quo_q[WIDTH-1]};
  assign trial = shift - {1'b0, dvs_q};

  assign q_fin = qneg_q ? ('0 - quo_q) : quo_q;
  assign r_fin = rneg_q ? ('0 - rem_q) : rem_q;
  assign fin   = {r_fin, q_fin};

  assign last_it = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          cnt_d = '0;
          if (b == '0) begin
            // Divide by zero: HI = raw dividend, LO = all ones.
            rem_d   = a;
            quo_d   = '1;
            dvs_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            qneg_d  = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d  = a_neg;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (last_it) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!cancel) begin
          res_d = fin;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (cancel) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign stall_divE = start & ~cancel & (state_q != S_DONE);
  assign ready      = (state_q == S_DONE) & ~cancel;
  assign result     = ready ? fin : res_q;

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed bench for div_iter against an arithmetic reference.
// A per-cycle monitor predicts stall/ready/result from latency and plain division.
module tb_div_iter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_div;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic          stall_divE;
  logic          ready;
  logic [2*W-1:0] result;

  int checks   = 0;
  int failures = 0;

  div_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .cancel     (cancel),
    .stall_divE (stall_divE),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(
    input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, q, r;
    logic [31:0] uq, ur;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
    end
    uq = x / y;
    ur = x % y;
    return {ur, uq};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle-level expectation: accept at cycle 0, ready at cycle lat.
  logic        m_on = 1'b0;
  logic        m_busy = 1'b0;
  int          m_cyc = 0;
  int          m_lat = 0;
  logic [63:0] m_res = '0;
  logic [63:0] m_last = '0;

  always @(negedge clk) begin
    logic e_stall, e_ready;
    logic [63:0] e_res;
    if (m_on) begin
      e_stall = start & ~cancel;
      e_ready = 1'b0;
      e_res   = m_last;
      if (m_busy && m_cyc == m_lat) begin
        e_stall = 1'b0;
        e_ready = ~cancel;
        e_res   = cancel ? m_last : m_res;
      end
      chk("mon_stall", {63'd0, stall_divE}, {63'd0, e_stall});
      chk("mon_ready", {63'd0, ready}, {63'd0, e_ready});
      chk("mon_result", result, e_res);
    end
    if (rst) begin
      m_on   = 1'b1;
      m_busy = 1'b0;
      m_last = '0;
    end else if (m_on) begin
      if (cancel) begin
        m_busy = 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cyc  = 1;
          m_lat  = (b == '0) ? 1 : W + 1;
          m_res  = ref_div(a, b, signed_div);
        end
      end else if (m_cyc == m_lat) begin
        m_busy = 1'b0;
        m_last = m_res;
      end else begin
        m_cyc++;
      end
    end
  end

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic s, output logic [63:0] res,
                        output int stalls);
    bit got = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    a = x;
    b = y;
    signed_div = s;
    stalls = 0;
    res = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (stall_divE) stalls++;
      if (ready) begin
        got = 1;
        res = result;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL op_timeout: got no ready expected ready within 100");
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  logic [63:0] r;
  logic [63:0] r0;
  int          st;
  logic [31:0] ra, rb;
  logic        rs;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    a = '0;
    b = '0;
    cancel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_stall", {63'd0, stall_divE}, 64'd0);

    chk("mdl_neg7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),
        64'hFFFF_FFFF_FFFF_FFFD);
    chk("mdl_7_neg2", ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),
        64'h0000_0001_FFFF_FFFD);
    chk("mdl_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),
        64'h0000_0000_8000_0000);

    run_op(32'd100, 32'd7, 1'b0, r, st);
    chk("u100_7", r, {32'd2, 32'd14});
    chk("u100_7_stall", 64'(st), 64'd33);
    go_idle();
    go_idle();

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, r, st);
    chk("s_neg7_2", r, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, r, st);
    chk("s_7_neg2", r, 64'h0000_0001_FFFF_FFFD);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, st);
    chk("s_ovf", r, 64'h0000_0000_8000_0000);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, r, st);
    chk("u_max_1", r, 64'h0000_0000_FFFF_FFFF);
    go_idle();

    run_op(32'h1234, 32'd0, 1'b0, r, st);
    chk("div0", r, 64'h0000_1234_FFFF_FFFF);
    chk("div0_stall", 64'(st), 64'd1);
    go_idle();

    // Cancel on the 10th BUSY cycle, then restart two cycles later.
    r0 = result;
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    signed_div = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    chk("cxl_stall", {63'd0, stall_divE}, 64'd0);
    chk("cxl_ready", {63'd0, ready}, 64'd0);
    chk("cxl_result", result, r0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    start = 1'b0;
    run_op(32'd1000, 32'd3, 1'b0, r, st);
    chk("after_cxl", r, {32'd1, 32'd333});
    chk("after_cxl_stall", 64'(st), 64'd33);
    go_idle();

    // Reset in the middle of an operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 32'd50;
    b = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_stall", {63'd0, stall_divE}, 64'd0);

    run_op(32'd50, 32'd5, 1'b0, r, st);
    chk("b2b_0", r, {32'd0, 32'd10});
    run_op(32'd77, 32'd10, 1'b0, r, st);
    chk("b2b_1", r, {32'd7, 32'd7});
    chk("b2b_1_stall", 64'(st), 64'd33);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 15);
        3: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, r, st);
      chk("rand_op", r, ref_div(ra, rb, rs));
      repeat ($urandom_range(0, 2)) go_idle();
    end
    go_idle();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
